signal_meter: RTL

//  Parametrised multi-channel, multi-mode meter. Successor to the single-channel FrequencyMeter.

---
 rtl/signal_meter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/signal_meter.sv
// signal_meter: NCH-channel frequency / period / duty (permille) meter feeding one result path.
// Define AUTO_RESTART_EN to re-arm continuously with the latched Mode/ChSel after every result.
module signal_meter #(
    parameter int unsigned NCH            = 4,
    parameter int unsigned W              = 16,
    parameter int unsigned GATE_CYCLES    = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
    localparam int unsigned CW            = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Start,
    input  logic [1:0]     Mode,
    input  logic [CW-1:0]  ChSel,
    input  logic [NCH-1:0] Sig,
    output logic [W-1:0]   Result,
    output logic           Valid,
    output logic           Busy,
    output logic           Overflow,
    output logic           Timeout
);

    localparam int unsigned TMAX = (GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned DW   = $clog2(W + 10);
    localparam int unsigned NW   = W + 10;

    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(W + 9);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FREQ,
        S_ARM,
        S_MEAS,
        S_DIV,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        M_FREQ   = 2'b00,
        M_PERIOD = 2'b01,
        M_DUTY   = 2'b10
    } mode_e;

    state_e         state_q;
    mode_e          mode_q;
    mode_e          start_mode;
    logic [CW-1:0]  ch_q;

    logic [NCH-1:0] sync1_q, sync2_q, sync3_q;
    logic           sel_lvl, sel_edge;

    logic [W-1:0]   cnt_q, high_q;
    logic [W-1:0]   cnt_inc, high_inc;
    logic           cnt_sat, high_sat;
    logic [TW-1:0]  tmr_q;
    logic           ovf_q, tmo_q;

    logic [W:0]     rem_q, rem_sh, rem_d;
    logic [NW-1:0]  quo_q, quo_d;
    logic           qbit;
    logic [DW-1:0]  step_q;

    logic [W-1:0]   result_q, done_result;
    logic           valid_q, busy_q, overflow_q, timeout_q;

    always_comb begin
        sel_lvl  = sync2_q[ch_q];
        sel_edge = sel_lvl & ~sync3_q[ch_q];

        cnt_sat  = &cnt_q;
        high_sat = &high_q;
        cnt_inc  = cnt_sat  ? cnt_q  : cnt_q  + 1'b1;
        high_inc = high_sat ? high_q : high_q + 1'b1;

        // One restoring-division step: numerator bits shift out of quo_q as quotient bits shift in.
        rem_sh = {rem_q[W-1:0], quo_q[NW-1]};
        if (rem_sh >= {1'b0, cnt_q}) begin
            rem_d = rem_sh - {1'b0, cnt_q};
            qbit  = 1'b1;
        end else begin
            rem_d = rem_sh;
            qbit  = 1'b0;
        end
        quo_d = {quo_q[NW-2:0], qbit};

        if (Mode == 2'b01) begin
            start_mode = M_PERIOD;
        end else if (Mode == 2'b10) begin
            start_mode = M_DUTY;
        end else begin
            start_mode = M_FREQ;
        end

        if (tmo_q) begin
            done_result = '0;
        end else if (mode_q == M_DUTY) begin
            done_result = ovf_q ? '0 : quo_q[W-1:0];
        end else begin
            done_result = cnt_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            state_q    <= S_IDLE;
            mode_q     <= M_FREQ;
            ch_q       <= '0;
            cnt_q      <= '0;
            high_q     <= '0;
            tmr_q      <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            step_q     <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            sync1_q <= Sig;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        mode_q  <= start_mode;
                        ch_q    <= ChSel;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        high_q  <= '0;
                        tmr_q   <= '0;
                        ovf_q   <= 1'b0;
                        tmo_q   <= 1'b0;
                        state_q <= (start_mode == M_FREQ) ? S_FREQ : S_ARM;
                    end
                end

                S_FREQ: begin
                    if (sel_edge) begin
                        cnt_q <= cnt_inc;
                        if (cnt_sat) ovf_q <= 1'b1;
                    end
                    tmr_q <= tmr_q + 1'b1;
                    if (tmr_q >= GATE_LAST) state_q <= S_DONE;
                end

                S_ARM: begin
                    tmr_q <= tmr_q + 1'b1;
                    if (sel_edge) begin
                        cnt_q   <= W'(1);
                        high_q  <= W'(1);
                        state_q <= S_MEAS;
                    end else if (tmr_q >= TMO_LAST) begin
                        tmo_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                S_MEAS: begin
                    tmr_q <= tmr_q + 1'b1;
                    if (sel_edge) begin
                        if (mode_q == M_DUTY && !ovf_q) begin
                            rem_q   <= '0;
                            quo_q   <= {10'b0, high_q} * NW'(1000);
                            step_q  <= '0;
                            state_q <= S_DIV;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end else if (tmr_q >= TMO_LAST) begin
                        tmo_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (sel_lvl) high_q <= high_inc;
                        if (cnt_sat || (sel_lvl && high_sat)) ovf_q <= 1'b1;
                    end
                end

                S_DIV: begin
                    rem_q  <= rem_d;
                    quo_q  <= quo_d;
                    step_q <= step_q + 1'b1;
                    if (step_q == DIV_LAST) state_q <= S_DONE;
                end

                S_DONE: begin
                    result_q   <= done_result;
                    overflow_q <= ovf_q;
                    timeout_q  <= tmo_q;
                    valid_q    <= 1'b1;
`ifdef AUTO_RESTART_EN
                    high_q <= '0;
                    ovf_q  <= 1'b0;
                    tmo_q  <= 1'b0;
                    // In frequency mode the DONE cycle is the first gate cycle of the next window,
                    // so back-to-back gates stay exactly GATE_CYCLES long with no blind cycle.
                    if (mode_q == M_FREQ) begin
                        cnt_q   <= sel_edge ? W'(1) : '0;
                        tmr_q   <= TW'(1);
                        state_q <= S_FREQ;
                    end else begin
                        cnt_q   <= '0;
                        tmr_q   <= '0;
                        state_q <= S_ARM;
                    end
`else
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
`endif
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Result   = result_q;
    assign Valid    = valid_q;
    assign Busy     = busy_q;
    assign Overflow = overflow_q;
    assign Timeout  = timeout_q;

endmodule
